mesh_router_sync: RTL and testbench



---
 rtl/router_pkg.sv | 41 ++++
 rtl/mesh_router_sync_if.sv | 52 +++++
 rtl/router_in_fifo.sv | 56 +++++
 rtl/mesh_router_sync.sv | 184 ++++++++++++++++++
 tb/tb_mesh_router_sync.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// router_pkg
//
// Definitions shared by every router variant in the mesh family.
// Contents:
//   port_e        - link port numbering (LOCAL, NORTH, EAST, SOUTH, WEST)
//   NPORTS        - number of links per router
//   router_type_e - router implementation variants
//   destx_lsb()   - LSB position of the destination-x field in an N-bit flit
//   desty_lsb()   - LSB position of the destination-y field in an N-bit flit
//   payload_w()   - payload width left after both coordinate fields
package router_pkg;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        EAST  = 3'd2,
        SOUTH = 3'd3,
        WEST  = 3'd4
    } port_e;

    localparam int NPORTS = 5;

    typedef enum logic [1:0] {
        ASYNC_CORNER = 2'd0,
        MESHSYNC     = 2'd1
    } router_type_e;

    // Flit layout: [N-1 -: CW] dest x, next CW bits dest y, remainder payload.
    function automatic int destx_lsb(input int n, input int cw);
        return n - cw;
    endfunction

    function automatic int desty_lsb(input int n, input int cw);
        return n - 2 * cw;
    endfunction

    function automatic int payload_w(input int n, input int cw);
        return n - 2 * cw;
    endfunction

endpackage

// File: rtl/mesh_router_sync_if.sv
// mesh_router_sync_if
//
// Bundles the five input links, five output links and status outputs of one
// mesh_router_sync instance. Each link is a 2-phase toggle req/ack pair plus
// a flit bus; a link has a transfer pending while req != ack.
//   in_req/in_data  - upstream neighbours -> router
//   in_ack          - router -> upstream neighbours
//   out_req/out_data- router -> downstream neighbours
//   out_ack         - downstream neighbours -> router
//   drop            - one-cycle pulse when out-of-range flits are discarded
//   fwd_cnt/drop_cnt- saturating statistics, present only with
//                     ROUTER_PERF_CNT_EN defined
// Modports: master = router side, slave = neighbour/environment side.
interface mesh_router_sync_if #(
    parameter int N = 32
);
    import router_pkg::*;

    logic [NPORTS-1:0]         in_req;
    logic [NPORTS-1:0][N-1:0]  in_data;
    logic [NPORTS-1:0]         in_ack;
    logic [NPORTS-1:0]         out_req;
    logic [NPORTS-1:0][N-1:0]  out_data;
    logic [NPORTS-1:0]         out_ack;
    logic                      drop;

`ifdef ROUTER_PERF_CNT_EN
    logic [NPORTS-1:0][15:0]   fwd_cnt;
    logic [15:0]               drop_cnt;

    modport master (
        input  in_req, in_data, out_ack,
        output in_ack, out_req, out_data, drop, fwd_cnt, drop_cnt
    );

    modport slave (
        output in_req, in_data, out_ack,
        input  in_ack, out_req, out_data, drop, fwd_cnt, drop_cnt
    );
`else
    modport master (
        input  in_req, in_data, out_ack,
        output in_ack, out_req, out_data, drop
    );

    modport slave (
        output in_req, in_data, out_ack,
        input  in_ack, out_req, out_data, drop
    );
`endif

endinterface

// File: rtl/router_in_fifo.sv
// router_in_fifo
//
// Per-input flit buffer of the mesh router: a circular buffer with a
// first-word-fall-through head.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (empties the buffer)
//   push/wdata - write one flit; caller only pushes when count < DEPTH
//   pop        - discard the head; caller only pops when count != 0
//   count      - flits currently held
//   head       - oldest flit, valid while count != 0
// Push and pop in the same cycle are allowed.
module router_in_fifo #(
    parameter int N     = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [N-1:0]             wdata,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic [N-1:0]             head
);
    localparam int AW = $clog2(DEPTH);

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [AW:0]   cnt_q;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage carries no reset; the count alone says what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= wdata;
    end

    assign head  = mem[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/mesh_router_sync.sv
// mesh_router_sync
//
// Clocked 5-port mesh router. Each input link (2-phase toggle req/ack) feeds a
// router_in_fifo; FIFO heads are routed XY dimension-order on absolute
// destination coordinates and each idle output link grants one requesting
// head per cycle through its own round-robin pointer.
// Ports:
//   clk   - router clock
//   rst_n - asynchronous active-low reset, shared with the neighbours
//   bus   - mesh_router_sync_if.master: in_req/in_data/in_ack,
//           out_req/out_data/out_ack, drop (and fwd_cnt/drop_cnt)
// Optional feature: define ROUTER_PERF_CNT_EN to add per-output forwarded
// flit counters and a drop counter (16-bit, saturating at 16'hFFFF).
// Latency: a flit captured at edge k into an empty FIFO whose output is idle
// is granted, and out_req toggles, at edge k+1.
module mesh_router_sync #(
    parameter int N     = 32,
    parameter int CW    = 2,
    parameter int DEPTH = 2,
    parameter int SRCX  = 0,
    parameter int SRCY  = 0,
    parameter int MAXX  = 1,
    parameter int MAXY  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    mesh_router_sync_if.master bus
);
    import router_pkg::*;

    localparam int CNTW = $clog2(DEPTH) + 1;

    localparam logic [CW-1:0] SRCX_C = CW'(SRCX);
    localparam logic [CW-1:0] SRCY_C = CW'(SRCY);
    localparam logic [CW-1:0] MAXX_C = CW'(MAXX);
    localparam logic [CW-1:0] MAXY_C = CW'(MAXY);

    logic [NPORTS-1:0]            in_ack_q;
    logic [NPORTS-1:0]            out_req_q;
    logic [NPORTS-1:0][N-1:0]     out_data_q;
    logic [NPORTS-1:0][2:0]       ptr_q;
    logic                         drop_q;

    logic [NPORTS-1:0]            push;
    logic [NPORTS-1:0]            pop;
    logic [NPORTS-1:0][CNTW-1:0]  count;
    logic [NPORTS-1:0][N-1:0]     head;
    logic [NPORTS-1:0]            head_vld;
    logic [NPORTS-1:0]            head_oor;
    logic [NPORTS-1:0][2:0]       tgt;
    logic [NPORTS-1:0]            gnt_vld;
    logic [NPORTS-1:0][2:0]       gnt_idx;

    function automatic logic [2:0] route_of(input logic [N-1:0] f);
        logic [CW-1:0] dx;
        logic [CW-1:0] dy;
        dx = f[destx_lsb(N, CW) +: CW];
        dy = f[desty_lsb(N, CW) +: CW];
        if (dx > SRCX_C)      return EAST;
        else if (dx < SRCX_C) return WEST;
        else if (dy > SRCY_C) return NORTH;
        else if (dy < SRCY_C) return SOUTH;
        else                  return LOCAL;
    endfunction

    function automatic logic out_of_range(input logic [N-1:0] f);
        return (f[destx_lsb(N, CW) +: CW] > MAXX_C) ||
               (f[desty_lsb(N, CW) +: CW] > MAXY_C);
    endfunction

    function automatic logic [2:0] next_port(input logic [2:0] g);
        return (g == 3'(NPORTS - 1)) ? 3'd0 : g + 3'd1;
    endfunction

    for (genvar p = 0; p < NPORTS; p++) begin : g_in
        router_in_fifo #(
            .N     (N),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[p]),
            .wdata (bus.in_data[p]),
            .pop   (pop[p]),
            .count (count[p]),
            .head  (head[p])
        );
    end

    // Capture uses the pre-pop count: a full FIFO never accepts in the same
    // cycle its head leaves, the flit simply stays on the link one more cycle.
    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            head_vld[p] = (count[p] != '0);
            head_oor[p] = head_vld[p] && out_of_range(head[p]);
            tgt[p]      = route_of(head[p]);
            push[p]     = (bus.in_req[p] != in_ack_q[p]) &&
                          (count[p] < CNTW'(DEPTH));
        end
    end

    // Round-robin per idle output, searching from ptr_q[o] upward mod 5.
    // Each head names a single target, so no input can win two outputs.
    always_comb begin
        logic [3:0] sum;
        logic [2:0] idx;
        sum     = '0;
        idx     = '0;
        gnt_vld = '0;
        gnt_idx = '0;
        for (int o = 0; o < NPORTS; o++) begin
            if (out_req_q[o] == bus.out_ack[o]) begin
                for (int i = 0; i < NPORTS; i++) begin
                    sum = {1'b0, ptr_q[o]} + 4'(i);
                    if (sum >= 4'(NPORTS)) sum = sum - 4'(NPORTS);
                    idx = sum[2:0];
                    if (!gnt_vld[o] && head_vld[idx] && !head_oor[idx] &&
                        (tgt[idx] == 3'(o))) begin
                        gnt_vld[o] = 1'b1;
                        gnt_idx[o] = idx;
                    end
                end
            end
        end
    end

    // Out-of-range heads leave without competing for any output.
    always_comb begin
        pop = head_oor;
        for (int o = 0; o < NPORTS; o++) begin
            if (gnt_vld[o]) pop[gnt_idx[o]] = 1'b1;
        end
    end

    // Link state: ack toggles on capture, req toggles on grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ack_q   <= '0;
            out_req_q  <= '0;
            out_data_q <= '0;
            ptr_q      <= '0;
            drop_q     <= 1'b0;
        end else begin
            in_ack_q  <= in_ack_q ^ push;
            out_req_q <= out_req_q ^ gnt_vld;
            drop_q    <= |head_oor;
            for (int o = 0; o < NPORTS; o++) begin
                if (gnt_vld[o]) begin
                    out_data_q[o] <= head[gnt_idx[o]];
                    ptr_q[o]      <= next_port(gnt_idx[o]);
                end
            end
        end
    end

    assign bus.in_ack   = in_ack_q;
    assign bus.out_req  = out_req_q;
    assign bus.out_data = out_data_q;
    assign bus.drop     = drop_q;

`ifdef ROUTER_PERF_CNT_EN
    logic [NPORTS-1:0][15:0] fwd_cnt_q;
    logic [15:0]             drop_cnt_q;

    // drop_cnt follows the drop pulse: simultaneous drops count once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                if (gnt_vld[o] && (fwd_cnt_q[o] != 16'hFFFF))
                    fwd_cnt_q[o] <= fwd_cnt_q[o] + 16'd1;
            end
            if ((|head_oor) && (drop_cnt_q != 16'hFFFF))
                drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign bus.fwd_cnt  = fwd_cnt_q;
    assign bus.drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_mesh_router_sync.sv
// tb_mesh_router_sync
//
// Directed scoreboard bench for mesh_router_sync at node (1,1) of a 3x3 mesh.
// Stimulus pushes the expected (output port, flit) pairs into a queue; a
// monitor pops the first entry for an output whenever that output's req
// toggles. Sinks acknowledge one cycle after seeing a req toggle.
module tb_mesh_router_sync;
    import router_pkg::*;

    localparam int N = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mesh_router_sync_if #(.N(N)) bus ();

    mesh_router_sync #(
        .N     (N),
        .CW    (2),
        .DEPTH (2),
        .SRCX  (1),
        .SRCY  (1),
        .MAXX  (2),
        .MAXY  (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          port;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          drop_pulses = 0;
    logic [4:0]  seen_req;
    logic [4:0]  ack_pend;
    logic [4:0]  sink_en = 5'h1f;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic sb_check(input int o, input logic [31:0] d);
        int hit;
        hit = -1;
        for (int i = 0; i < sb.size(); i++) begin
            if (hit < 0 && sb[i].port == o) hit = i;
        end
        n_checks++;
        if (hit < 0) begin
            n_fail++;
            $display("FAIL out%0d_unexpected: got %h expected no flit", o, d);
        end else begin
            if (d !== sb[hit].data) begin
                n_fail++;
                $display("FAIL out%0d_data: got %h expected %h", o, d, sb[hit].data);
            end
            sb.delete(hit);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen_req = '0;
        end else begin
            for (int o = 0; o < 5; o++) begin
                if (bus.out_req[o] != seen_req[o]) begin
                    seen_req[o] = bus.out_req[o];
                    sb_check(o, bus.out_data[o]);
                end
            end
            if (bus.drop) drop_pulses++;
        end
    end

    // Sinks: acknowledge one cycle after a req toggle is first seen.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            bus.out_ack = '0;
            ack_pend    = '0;
        end else begin
            for (int o = 0; o < 5; o++) begin
                if (ack_pend[o]) begin
                    bus.out_ack[o] = bus.out_req[o];
                    ack_pend[o]    = 1'b0;
                end else if (sink_en[o] && (bus.out_req[o] != bus.out_ack[o])) begin
                    ack_pend[o] = 1'b1;
                end
            end
        end
    end

    task automatic drive(input int p, input logic [31:0] d, input int o);
        bus.in_data[p] = d;
        bus.in_req[p]  = ~bus.in_req[p];
        if (o >= 0) sb.push_back('{o, d});
    endtask

    task automatic wait_ack(input int p, input string nm);
        int k;
        k = 0;
        while ((bus.in_ack[p] != bus.in_req[p]) && (k < 20)) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(nm, bus.in_ack[p] == bus.in_req[p], 1);
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while (((sb.size() != 0) || (bus.out_req != bus.out_ack)) && (k < 100)) begin
            @(negedge clk);
            k++;
        end
        check(nm, k < 100, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int         d0;
        logic [4:0] snap;
        logic       ack0;

        rst_n       = 1'b0;
        bus.in_req  = '0;
        bus.in_data = '0;
        #1;
        check("rst_in_ack",   bus.in_ack, 0);
        check("rst_out_req",  bus.out_req, 0);
        check("rst_out_data", |bus.out_data, 0);
        check("rst_drop",     bus.drop, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // LOCAL -> (2,1): EAST, one-cycle grant latency
        drive(0, 32'h9FFFFFFF, 2);
        @(posedge clk); #1;
        check("s1_ack_at_capture", bus.in_ack[0], 1);
        check("s1_req_not_early",  bus.out_req[2], 0);
        @(posedge clk); #1;
        check("s1_req_next_edge",  bus.out_req[2], 1);
        wait_idle("s1_idle");

        // WEST -> (1,2): NORTH; SOUTH -> (1,1): LOCAL
        drive(4, 32'h6EEEEEEE, 1);
        wait_ack(4, "s2_west_ack");
        @(negedge clk);
        drive(3, 32'h5DDDDDDD, 0);
        wait_ack(3, "s2_south_ack");
        wait_idle("s2_idle");

        // NORTH, EAST, SOUTH to LOCAL in one cycle; pointer starts at WEST
        @(negedge clk);
        drive(1, 32'h50000001, 0);
        drive(2, 32'h50000002, 0);
        drive(3, 32'h50000003, 0);
        wait_ack(1, "s3_north_ack");
        wait_ack(2, "s3_east_ack");
        wait_ack(3, "s3_south_ack");
        wait_idle("s3_idle");

        // pointer now at WEST: WEST beats NORTH
        @(negedge clk);
        drive(4, 32'h50000014, 0);
        drive(1, 32'h50000011, 0);
        wait_idle("s3_rr_idle");

        // out-of-range drops
        snap = bus.out_req;
        d0   = drop_pulses;
        @(negedge clk);
        drive(0, 32'hD1234567, -1);
        wait_ack(0, "s5_drop_ack");
        repeat (4) @(posedge clk);
        #1;
        check("s5_drop_pulses", drop_pulses - d0, 1);
        check("s5_no_out_req",  bus.out_req, snap);
`ifdef ROUTER_PERF_CNT_EN
        check("s5_drop_cnt",    bus.drop_cnt, 1);
        check("s5_fwd_cnt_loc", bus.fwd_cnt[0], 6);
`endif
        @(negedge clk);
        drive(0, 32'hC0000001, -1);
        drive(4, 32'h30000002, -1);
        wait_ack(0, "s5_dual_ack0");
        wait_ack(4, "s5_dual_ack4");
        repeat (4) @(posedge clk);
        #1;
        check("s5_dual_one_pulse", drop_pulses - d0, 2);
        check("s5_dual_no_req",    bus.out_req, snap);

        // EAST sink stalls; fill FIFO and hold the 4th flit on the link
        sink_en[2] = 1'b0;
        for (int f = 1; f <= 3; f++) begin
            @(negedge clk);
            drive(0, 32'h90000000 + 32'(f), 2);
            wait_ack(0, "s4_ack_fill");
        end
        @(negedge clk);
        drive(0, 32'h90000004, 2);
        repeat (6) @(posedge clk);
        #1;
        check("s4_ack_withheld", bus.in_ack[0] != bus.in_req[0], 1);
        ack0 = bus.out_ack[2];
        sink_en[2] = 1'b1;
        wait_ack(0, "s4_4th_ack");
        check("s4_after_out_ack", bus.out_ack[2] != ack0, 1);

        // reset with flits buffered
        rst_n       = 1'b0;
        bus.in_req  = '0;
        sb.delete();
        #1;
        check("s6_in_ack",   bus.in_ack, 0);
        check("s6_out_req",  bus.out_req, 0);
        check("s6_out_data", |bus.out_data, 0);
        check("s6_drop",     bus.drop, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        drive(0, 32'h9ABCDEF0, 2);
        @(posedge clk); #1;
        check("s6_ack_capture", bus.in_ack[0], 1);
        @(posedge clk); #1;
        check("s6_req_next",    bus.out_req[2], 1);
        wait_idle("s6_idle");

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
